dispense_timer_sched: RTL and testbench

- Shares one prescaled countdown timer among NUM_REQ dispense channels, for example motor or solenoid slots.
- Each channel requests a timed interval, measured in ticks of a prescaled timebase derived from the 12 MHz OSCH-derived system clock.
- The block arbitrates among requests, runs the granted interval, then pulses done back to the owning channel.
- It sits between the dispense control logic and the clock-division timebase, and is the only owner of the interval timer.

---
 rtl/dispense_timer_sched.sv | 118 +++++++++++
 tb/tb_dispense_timer_sched.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/dispense_timer_sched.sv
// Shares one prescaled interval timer among NUM_REQ channels; optional macro ROUND_ROBIN_EN selects round-robin arbitration (default: fixed priority).
// Latency: req to grant 2 cycles, final tick to done 1 cycle; requests are level-held, and a dropped owner request or abort_i cancels.
module dispense_timer_sched #(
    parameter int NUM_REQ  = 4,
    parameter int PRESCALE = 12000,
    parameter int DUR_W    = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_i,
    input  logic [NUM_REQ*DUR_W-1:0] dur_i,
    input  logic                     abort_i,
    output logic [NUM_REQ-1:0]       grant_o,
    output logic [NUM_REQ-1:0]       done_o,
    output logic                     busy_o,
    output logic                     tick_o,
    output logic [DUR_W-1:0]         remain_o
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int PS_W  = $clog2(PRESCALE);
    localparam logic [PS_W-1:0]  PS_MAX  = PS_W'(PRESCALE - 1);
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {IDLE, ARB, RUN, DONE} state_t;

    state_t           state;
    logic [IDX_W-1:0] owner;
    logic [DUR_W-1:0] cnt;
    logic [PS_W-1:0]  psc;
    logic [IDX_W-1:0] win_idx;
    logic [DUR_W-1:0] win_dur;

`ifdef ROUND_ROBIN_EN
    logic [IDX_W-1:0] rr_ptr;

    // Descending scan so the smallest offset from the pointer wins.
    always_comb begin
        win_idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_i[(int'(rr_ptr) + i) % NUM_REQ]) begin
                win_idx = IDX_W'((int'(rr_ptr) + i) % NUM_REQ);
            end
        end
    end
`else
    always_comb begin
        win_idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                win_idx = IDX_W'(i);
            end
        end
    end
`endif

    assign win_dur = dur_i[int'(win_idx)*DUR_W +: DUR_W];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            owner <= '0;
            cnt   <= '0;
            psc   <= '0;
`ifdef ROUND_ROBIN_EN
            rr_ptr <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (|req_i) begin
                        state <= ARB;
                    end
                end
                ARB: begin
`ifdef ROUND_ROBIN_EN
                    if (|req_i) begin
                        rr_ptr <= (win_idx == IDX_MAX) ? '0 : win_idx + 1'b1;
                    end
`endif
                    if (abort_i || !(|req_i)) begin
                        state <= IDLE;
                    end else begin
                        owner <= win_idx;
                        cnt   <= win_dur;
                        psc   <= '0;
                        state <= (win_dur == '0) ? DONE : RUN;
                    end
                end
                RUN: begin
                    // Cancellation outranks a tick or completion in the same cycle.
                    if (abort_i || !req_i[owner]) begin
                        state <= IDLE;
                    end else if (psc == PS_MAX) begin
                        psc <= '0;
                        cnt <= cnt - 1'b1;
                        if (cnt == DUR_W'(1)) begin
                            state <= DONE;
                        end
                    end else begin
                        psc <= psc + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Outputs decode registered state only, so reset clears them immediately.
    assign grant_o  = (state == RUN)  ? (NUM_REQ'(1) << owner) : '0;
    assign done_o   = (state == DONE) ? (NUM_REQ'(1) << owner) : '0;
    assign busy_o   = (state != IDLE);
    assign tick_o   = (state == RUN) && (psc == PS_MAX);
    assign remain_o = (state == RUN) ? cnt : '0;

endmodule

// File: tb/tb_dispense_timer_sched.sv
// Directed bench for dispense_timer_sched with PRESCALE=4, NUM_REQ=4, DUR_W=16.
module tb_dispense_timer_sched;

    localparam int NR = 4;
    localparam int DW = 16;

    logic           clk;
    logic           rst;
    logic [NR-1:0]  req_i;
    logic [NR*DW-1:0] dur_i;
    logic           abort_i;
    logic [NR-1:0]  grant_o;
    logic [NR-1:0]  done_o;
    logic           busy_o;
    logic           tick_o;
    logic [DW-1:0]  remain_o;

    int n_checks = 0;
    int n_errors = 0;

    dispense_timer_sched #(.NUM_REQ(NR), .PRESCALE(4), .DUR_W(DW)) dut (
        .clk      (clk),
        .rst      (rst),
        .req_i    (req_i),
        .dur_i    (dur_i),
        .abort_i  (abort_i),
        .grant_o  (grant_o),
        .done_o   (done_o),
        .busy_o   (busy_o),
        .tick_o   (tick_o),
        .remain_o (remain_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        cyc(1);
    endtask

    // Entered in IDLE with requests set; every duration is 1 tick.
    task automatic serve(input int ch, input bit rereq);
        logic [NR-1:0] oh;
        oh = NR'(1) << ch;
        cyc(2);
        chk($sformatf("rr_grant_ch%0d", ch), grant_o, oh);
        cyc(4);
        chk($sformatf("rr_done_ch%0d", ch), done_o, oh);
        req_i[ch] = 1'b0;
        cyc(1);
        chk("rr_idle", busy_o, 0);
        if (rereq) req_i[ch] = 1'b1;
    endtask

    initial begin
        rst = 1'b1;
        req_i = '0;
        dur_i = '0;
        abort_i = 1'b0;
        cyc(2);
        chk("rst_grant", grant_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_tick", tick_o, 0);
        chk("rst_remain", remain_o, 0);
        rst = 1'b0;
        cyc(1);

        // Single request, 3 ticks
        dur_i[0 +: DW] = 16'd3;
        req_i = 4'b0001;
        cyc(1);
        chk("s_arb_busy", busy_o, 1);
        chk("s_arb_grant", grant_o, 0);
        cyc(1);
        chk("s_grant", grant_o, 4'b0001);
        chk("s_remain0", remain_o, 3);
        chk("s_notick", tick_o, 0);
        cyc(3);
        chk("s_tick1", tick_o, 1);
        chk("s_rem_t1", remain_o, 3);
        cyc(1);
        chk("s_tick_off", tick_o, 0);
        chk("s_rem2", remain_o, 2);
        cyc(3);
        chk("s_tick2", tick_o, 1);
        cyc(4);
        chk("s_tick3", tick_o, 1);
        chk("s_rem_t3", remain_o, 1);
        cyc(1);
        chk("s_done", done_o, 4'b0001);
        chk("s_done_grant", grant_o, 0);
        chk("s_done_remain", remain_o, 0);
        req_i = '0;
        cyc(1);
        chk("s_busy_fall", busy_o, 0);
        chk("s_done_pulse", done_o, 0);
        cyc(1);
        chk("s_no_regrant", busy_o, 0);

        // Zero duration
        dur_i = '0;
        req_i = 4'b0100;
        cyc(1);
        chk("z_arb_done", done_o, 0);
        cyc(1);
        chk("z_done", done_o, 4'b0100);
        chk("z_grant", grant_o, 0);
        chk("z_tick", tick_o, 0);
        req_i = '0;
        cyc(1);
        chk("z_idle", busy_o, 0);

        // Abort on the 2nd tick
        dur_i[1*DW +: DW] = 16'd5;
        req_i = 4'b0010;
        cyc(2);
        chk("a_grant", grant_o, 4'b0010);
        cyc(3);
        chk("a_tick1", tick_o, 1);
        cyc(4);
        chk("a_tick2", tick_o, 1);
        chk("a_rem", remain_o, 4);
        abort_i = 1'b1;
        cyc(1);
        abort_i = 1'b0;
        req_i = '0;
        chk("a_busy", busy_o, 0);
        chk("a_done", done_o, 0);
        chk("a_remain", remain_o, 0);
        chk("a_grant_off", grant_o, 0);
        cyc(1);
        chk("a_done_late", done_o, 0);

        // Owner drops its request mid-RUN
        req_i = 4'b0010;
        cyc(2);
        chk("d_grant", grant_o, 4'b0010);
        cyc(5);
        req_i = '0;
        cyc(1);
        chk("d_busy", busy_o, 0);
        chk("d_done", done_o, 0);
        chk("d_remain", remain_o, 0);
        cyc(1);
        chk("d_done_late", done_o, 0);

        // Asynchronous reset mid-RUN, request held through it
        dur_i[0 +: DW] = 16'd2;
        req_i = 4'b0001;
        cyc(2);
        chk("r_grant", grant_o, 4'b0001);
        cyc(3);
        #2;
        rst = 1'b1;
        #1;
        chk("r_async_grant", grant_o, 0);
        chk("r_async_busy", busy_o, 0);
        chk("r_async_remain", remain_o, 0);
        chk("r_async_tick", tick_o, 0);
        chk("r_async_done", done_o, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc(2);
        chk("r_regrant", grant_o, 4'b0001);
        chk("r_full_len", remain_o, 2);
        cyc(7);
        chk("r_last_tick", tick_o, 1);
        chk("r_last_rem", remain_o, 1);
        cyc(1);
        chk("r_done", done_o, 4'b0001);
        req_i = '0;
        cyc(1);
        chk("r_idle", busy_o, 0);

        // Contention, durations all 1
        do_reset();
        dur_i = {16'd1, 16'd1, 16'd1, 16'd1};
        req_i = 4'b1011;
        serve(0, 1'b0);
        serve(1, 1'b0);
        serve(3, 1'b0);
        chk("c_all_dropped", req_i, 0);
        req_i = 4'b1011;
`ifdef ROUND_ROBIN_EN
        serve(0, 1'b1);
        serve(1, 1'b1);
        serve(3, 1'b1);
        serve(0, 1'b1);
`else
        serve(0, 1'b1);
        serve(0, 1'b1);
        serve(0, 1'b1);
        serve(0, 1'b1);
`endif
        req_i = '0;
        cyc(2);
        chk("c_final_idle", busy_o, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
